// File: rtl/mac_tx_arbiter_pkg.sv
// Shared types and constants for the two-requester MAC transmit arbiter.
package mac_tx_arbiter_pkg;

   // Byte-enable code on the final word of a frame, MSB-first.
   localparam logic [1:0] BE_4B = 2'b00;
   localparam logic [1:0] BE_1B = 2'b01;
   localparam logic [1:0] BE_2B = 2'b10;
   localparam logic [1:0] BE_3B = 2'b11;

   localparam int PORT_ARP = 0;
   localparam int PORT_IP  = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      GAP  = 2'd2
   } state_e;

   // drain qualifies GAP: discard the rest of a truncated frame before the gap.
   typedef struct packed {
      state_e state;
      logic   drain;
   } fsm_t;

endpackage

// File: rtl/mac_tx_arbiter_rr_arb2.sv
// Two-way round-robin grant: on a tie the port that did not win last time wins.
module rr_arb2 (
   input  logic [1:0] request,
   input  logic [1:0] last,
   output logic [1:0] grant
);

   always_comb begin
      grant = request;
      if (request == 2'b11) begin
         grant = (last == 2'b01) ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Arbitrates the ARP and IPv4/UDP frame streams onto one MAC transmit port,
// with an inter-frame gap and a per-frame word watchdog.
//
// state        | meaning
// IDLE         | no owner; arbitrate sop requests, flush stray non-sop words
// BUSY         | granted source passed straight through to the MAC
// GAP          | grant dropped; down-count the inter-frame gap
// GAP + drain  | discard the remainder of a truncated frame up to its eop
module mac_tx_arbiter
   import mac_tx_arbiter_pkg::*;
#(
   parameter int GAP_CYCLES = 2,
   parameter int MAX_WORDS  = 384
) (
   input  logic        clk_user_i,
   input  logic        reset_n_i,
   input  logic        s0_vld_i,
   input  logic        s0_sop_i,
   input  logic        s0_eop_i,
   input  logic [31:0] s0_data_i,
   input  logic [1:0]  s0_be_i,
   output logic        s0_rd_o,
   input  logic        s1_vld_i,
   input  logic        s1_sop_i,
   input  logic        s1_eop_i,
   input  logic [31:0] s1_data_i,
   input  logic [1:0]  s1_be_i,
   output logic        s1_rd_o,
   output logic        mac_tx_vld_o,
   output logic        mac_tx_sop_o,
   output logic        mac_tx_eop_o,
   output logic [31:0] mac_tx_data_o,
   output logic [1:0]  mac_tx_be_o,
   input  logic        mac_tx_ready_i,
   output logic [1:0]  grant_o,
   output logic        abort_o
);

   localparam int CNT_W = ($clog2(MAX_WORDS + 1) > 9) ? $clog2(MAX_WORDS + 1) : 9;
   localparam int GAP_W = $clog2(GAP_CYCLES + 2);
   localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_WORDS - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

   fsm_t             fsm_q, fsm_d;
   logic [1:0]       grant_q, grant_d;
   logic [1:0]       last_q, last_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
   logic             armed_q;

   logic        src_vld, src_sop, src_eop;
   logic [31:0] src_data;
   logic [1:0]  src_be;
   logic [1:0]  req, arb_grant, flush;
   logic        idle, busy, draining, force_eop, xfer;

   assign idle     = (fsm_q.state == IDLE) & armed_q;
   assign busy     = (fsm_q.state == BUSY);
   assign draining = (fsm_q.state == GAP) & fsm_q.drain;

   // last_q equals grant_q while BUSY and names the truncated source while draining.
   always_comb begin
      if (last_q[PORT_IP]) begin
         src_vld  = s1_vld_i;
         src_sop  = s1_sop_i;
         src_eop  = s1_eop_i;
         src_data = s1_data_i;
         src_be   = s1_be_i;
      end else begin
         src_vld  = s0_vld_i;
         src_sop  = s0_sop_i;
         src_eop  = s0_eop_i;
         src_data = s0_data_i;
         src_be   = s0_be_i;
      end
   end

   assign req = {s1_vld_i & s1_sop_i, s0_vld_i & s0_sop_i};

   rr_arb2 u_rr_arb2 (
      .request (req),
      .last    (last_q),
      .grant   (arb_grant)
   );

   assign force_eop = busy & src_vld & (word_cnt_q == MAX_LAST) & ~src_eop;

   assign mac_tx_vld_o  = busy & src_vld;
   assign mac_tx_sop_o  = busy & src_sop;
   assign mac_tx_eop_o  = busy & (src_eop | force_eop);
   assign mac_tx_data_o = busy ? src_data : '0;
   assign mac_tx_be_o   = (busy & ~force_eop) ? src_be : BE_4B;
   assign grant_o       = grant_q;
   assign abort_o       = force_eop & mac_tx_ready_i;
   assign xfer          = mac_tx_vld_o & mac_tx_ready_i;

   assign flush[PORT_ARP] = idle & s0_vld_i & ~s0_sop_i & ~arb_grant[PORT_IP];
   assign flush[PORT_IP]  = idle & s1_vld_i & ~s1_sop_i & ~arb_grant[PORT_ARP];

   assign s0_rd_o = (grant_q[PORT_ARP] & mac_tx_ready_i & s0_vld_i)
                  | (draining & last_q[PORT_ARP] & s0_vld_i)
                  | flush[PORT_ARP];
   assign s1_rd_o = (grant_q[PORT_IP] & mac_tx_ready_i & s1_vld_i)
                  | (draining & last_q[PORT_IP] & s1_vld_i)
                  | flush[PORT_IP];

   always_comb begin
      fsm_d      = fsm_q;
      grant_d    = grant_q;
      last_d     = last_q;
      gap_cnt_d  = gap_cnt_q;
      word_cnt_d = word_cnt_q;
      case (fsm_q.state)
         IDLE: begin
            if (idle && (arb_grant != 2'b00)) begin
               fsm_d.state = BUSY;
               grant_d     = arb_grant;
               last_d      = arb_grant;
               word_cnt_d  = '0;
            end
         end
         BUSY: begin
            if (xfer) begin
               word_cnt_d = word_cnt_q + 1'b1;
               if (mac_tx_eop_o) begin
                  grant_d = '0;
                  if (force_eop) begin
                     fsm_d.state = GAP;
                     fsm_d.drain = 1'b1;
                  end else if (GAP_CYCLES == 0) begin
                     fsm_d.state = IDLE;
                  end else begin
                     fsm_d.state = GAP;
                     gap_cnt_d   = GAP_LOAD;
                  end
               end
            end
         end
         GAP: begin
            if (fsm_q.drain) begin
               if (src_vld && src_eop) begin
                  fsm_d.drain = 1'b0;
                  if (GAP_CYCLES == 0) begin
                     fsm_d.state = IDLE;
                  end else begin
                     gap_cnt_d = GAP_LOAD;
                  end
               end
            end else if (gap_cnt_q == '0) begin
               fsm_d.state = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - 1'b1;
            end
         end
         default: begin
            fsm_d.state = IDLE;
            fsm_d.drain = 1'b0;
         end
      endcase
   end

   // armed_q holds off arbitration and flushing for the first edge after reset.
   always_ff @(posedge clk_user_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         fsm_q.state <= IDLE;
         fsm_q.drain <= 1'b0;
         grant_q     <= '0;
         last_q      <= 2'b10;
         gap_cnt_q   <= '0;
         word_cnt_q  <= '0;
         armed_q     <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         grant_q     <= grant_d;
         last_q      <= last_d;
         gap_cnt_q   <= gap_cnt_d;
         word_cnt_q  <= word_cnt_d;
         armed_q     <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Bench for mac_tx_arbiter: IDLE vector table, then frame-level scenarios
// checked through per-port expected-word queues.
module tb_mac_tx_arbiter;
   import mac_tx_arbiter_pkg::*;

   typedef struct packed {
      logic        sop;
      logic        eop;
      logic [31:0] data;
      logic [1:0]  be;
   } word_t;

   typedef struct {
      logic       v0, p0, v1, p1;
      logic [1:0] rd;
      logic [1:0] gnt;
   } vec_t;

   logic        clk_user = 1'b0;
   logic        reset_n;
   logic        s0_vld, s0_sop, s0_eop, s1_vld, s1_sop, s1_eop;
   logic [31:0] s0_data, s1_data;
   logic [1:0]  s0_be, s1_be;
   logic        mac_tx_ready;
   logic        s0_rd, s1_rd, m_vld, m_sop, m_eop, m_abort;
   logic [31:0] m_data;
   logic [1:0]  m_be, m_grant;
   logic        w_s0_rd, w_s1_rd, w_vld, w_sop, w_eop, w_abort;
   logic [31:0] w_data;
   logic [1:0]  w_be, w_grant;

   always #5 clk_user = ~clk_user;

   mac_tx_arbiter #(.GAP_CYCLES(2), .MAX_WORDS(384)) dut (
      .clk_user_i(clk_user), .reset_n_i(reset_n),
      .s0_vld_i(s0_vld), .s0_sop_i(s0_sop), .s0_eop_i(s0_eop), .s0_data_i(s0_data),
      .s0_be_i(s0_be), .s0_rd_o(s0_rd),
      .s1_vld_i(s1_vld), .s1_sop_i(s1_sop), .s1_eop_i(s1_eop), .s1_data_i(s1_data),
      .s1_be_i(s1_be), .s1_rd_o(s1_rd),
      .mac_tx_vld_o(m_vld), .mac_tx_sop_o(m_sop), .mac_tx_eop_o(m_eop),
      .mac_tx_data_o(m_data), .mac_tx_be_o(m_be), .mac_tx_ready_i(mac_tx_ready),
      .grant_o(m_grant), .abort_o(m_abort)
   );

   mac_tx_arbiter #(.GAP_CYCLES(2), .MAX_WORDS(8)) dut_wd (
      .clk_user_i(clk_user), .reset_n_i(reset_n),
      .s0_vld_i(s0_vld), .s0_sop_i(s0_sop), .s0_eop_i(s0_eop), .s0_data_i(s0_data),
      .s0_be_i(s0_be), .s0_rd_o(w_s0_rd),
      .s1_vld_i(s1_vld), .s1_sop_i(s1_sop), .s1_eop_i(s1_eop), .s1_data_i(s1_data),
      .s1_be_i(s1_be), .s1_rd_o(w_s1_rd),
      .mac_tx_vld_o(w_vld), .mac_tx_sop_o(w_sop), .mac_tx_eop_o(w_eop),
      .mac_tx_data_o(w_data), .mac_tx_be_o(w_be), .mac_tx_ready_i(mac_tx_ready),
      .grant_o(w_grant), .abort_o(w_abort)
   );

   word_t src0_q[$], src1_q[$], exp0_q[$], exp1_q[$];
   int    port_log[$], sop_log[$], eop_log[$];
   int    n_cmp = 0, n_err = 0, cyc = 0, fid = 0;
   bit    model_on = 1'b0;
   int    ready_mode = 0, ready_idx = 0;
   logic  rd0_s, rd1_s;
   int    g0_cycles, bp_viol, stall_cycles, hold_viol, main_aborts, xfer_cnt;
   bit    prev_stall;
   logic [38:0] prev_out;
   int    wd_words, wd_aborts, wd_abort_word, wd_sop_last;
   word_t wd_word8;
   logic  rpat [4];
   vec_t  vt [9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      n_cmp++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
      end
   endtask

   task automatic drive_srcs();
      word_t w0, w1;
      w0 = (src0_q.size() > 0) ? src0_q[0] : '0;
      w1 = (src1_q.size() > 0) ? src1_q[0] : '0;
      s0_vld = (src0_q.size() > 0); s0_sop = w0.sop; s0_eop = w0.eop;
      s0_data = w0.data; s0_be = w0.be;
      s1_vld = (src1_q.size() > 0); s1_sop = w1.sop; s1_eop = w1.eop;
      s1_data = w1.data; s1_be = w1.be;
   endtask

   task automatic push_frame(input int port, input int n, input logic [1:0] last_be);
      word_t w;
      for (int k = 0; k < n; k++) begin
         w.sop  = (k == 0);
         w.eop  = (k == n - 1);
         w.data = {4'(port), 12'(fid), 16'(k)};
         w.be   = (k == n - 1) ? last_be : 2'(k);
         if (port == 0) begin
            src0_q.push_back(w); exp0_q.push_back(w);
         end else begin
            src1_q.push_back(w); exp1_q.push_back(w);
         end
      end
      fid++;
   endtask

   task automatic clear_bench();
      src0_q.delete(); src1_q.delete(); exp0_q.delete(); exp1_q.delete();
      port_log.delete(); sop_log.delete(); eop_log.delete();
      g0_cycles = 0; bp_viol = 0; stall_cycles = 0; hold_viol = 0;
      main_aborts = 0; xfer_cnt = 0; prev_stall = 1'b0;
      wd_words = 0; wd_aborts = 0; wd_abort_word = 0; wd_sop_last = 0; wd_word8 = '0;
      ready_mode = 0; ready_idx = 0; mac_tx_ready = 1'b1;
      drive_srcs();
   endtask

   // Reset both DUTs, release, and let one edge pass so they are armed.
   task automatic do_reset();
      reset_n = 1'b0;
      model_on = 1'b0;
      clear_bench();
      repeat (2) @(posedge clk_user);
      #1 reset_n = 1'b1;
      @(posedge clk_user);
      #1 model_on = 1'b1;
   endtask

   task automatic step();
      logic [38:0] cur;
      int p;
      word_t got, want, dw;
      @(negedge clk_user);
      cyc++;
      rd0_s = s0_rd; rd1_s = s1_rd;
      cur = {m_vld, m_sop, m_eop, m_data, m_be, m_grant};
      if (prev_stall && cur !== prev_out) hold_viol++;
      prev_stall = m_vld & ~mac_tx_ready;
      prev_out = cur;
      if (m_vld && !mac_tx_ready) stall_cycles++;
      if (!mac_tx_ready && m_grant != 2'b00 && (s0_rd || s1_rd)) bp_viol++;
      if (m_grant == 2'b01) g0_cycles++;
      if (m_abort) main_aborts++;
      if (m_vld && mac_tx_ready) begin
         xfer_cnt++;
         chk("grant_onehot", (m_grant == 2'b01 || m_grant == 2'b10), 1'b1);
         p = m_grant[1] ? 1 : 0;
         got = {m_sop, m_eop, m_data, m_be};
         if (p == 0 && exp0_q.size() > 0) begin
            want = exp0_q.pop_front();
            chk("word_p0", got, want);
         end else if (p == 1 && exp1_q.size() > 0) begin
            want = exp1_q.pop_front();
            chk("word_p1", got, want);
         end else begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_word: got 0x%0h on port %0d, expected no word", got, p);
         end
         if (m_sop) begin port_log.push_back(p); sop_log.push_back(cyc); end
         if (m_eop) eop_log.push_back(cyc);
      end
      if (w_vld && mac_tx_ready) begin
         wd_words++;
         if (wd_words == 8) wd_word8 = {w_sop, w_eop, w_data, w_be};
         if (w_sop) wd_sop_last = cyc;
      end
      if (w_abort) begin wd_aborts++; wd_abort_word = wd_words; end
      @(posedge clk_user);
      #1;
      if (model_on) begin
         if (rd0_s && src0_q.size() > 0) dw = src0_q.pop_front();
         if (rd1_s && src1_q.size() > 0) dw = src1_q.pop_front();
         if (ready_mode == 1) begin
            mac_tx_ready = rpat[ready_idx % 4];
            ready_idx++;
         end else begin
            mac_tx_ready = 1'b1;
         end
         drive_srcs();
      end
   endtask

   task automatic run_done(input string name, input int budget);
      int i;
      i = 0;
      while ((src0_q.size() + src1_q.size() + exp0_q.size() + exp1_q.size()) != 0 && i < budget) begin
         step();
         i++;
      end
      chk({name, "_all_words_done"}, src0_q.size() + src1_q.size() + exp0_q.size() + exp1_q.size(), 0);
      repeat (4) step();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
      $fatal(1);
   end

   initial begin
      int f, i;
      rpat[0] = 1'b1; rpat[1] = 1'b0; rpat[2] = 1'b0; rpat[3] = 1'b1;
      vt[0] = '{0, 0, 0, 0, 2'b00, 2'b00};
      vt[1] = '{1, 0, 0, 0, 2'b01, 2'b00};
      vt[2] = '{0, 0, 1, 0, 2'b10, 2'b00};
      vt[3] = '{1, 1, 0, 0, 2'b00, 2'b01};
      vt[4] = '{0, 0, 1, 1, 2'b00, 2'b10};
      vt[5] = '{1, 1, 1, 1, 2'b00, 2'b01};
      vt[6] = '{1, 1, 1, 0, 2'b00, 2'b01};
      vt[7] = '{1, 0, 1, 1, 2'b00, 2'b10};
      vt[8] = '{1, 0, 1, 0, 2'b11, 2'b00};
      reset_n = 1'b0;
      clear_bench();

      // reset state
      do_reset();
      @(negedge clk_user);
      chk("rst_grant", m_grant, 2'b00);
      chk("rst_mac", {m_vld, m_sop, m_eop, m_data, m_be, m_abort}, 0);
      chk("rst_rd", {s1_rd, s0_rd}, 2'b00);

      // IDLE decisions: request, tie, flush and flush suppression
      for (int k = 0; k < 9; k++) begin
         do_reset();
         model_on = 1'b0;
         s0_vld = vt[k].v0; s0_sop = vt[k].p0; s0_data = 32'hA0A0_0000 + k;
         s1_vld = vt[k].v1; s1_sop = vt[k].p1; s1_data = 32'hB1B1_0000 + k;
         @(negedge clk_user);
         chk($sformatf("vec%0d_rd", k), {s1_rd, s0_rd}, vt[k].rd);
         chk($sformatf("vec%0d_idle_vld", k), m_vld, 1'b0);
         @(negedge clk_user);
         chk($sformatf("vec%0d_grant", k), m_grant, vt[k].gnt);
      end

      // single ARP frame then a second one: grant length and 2-cycle gap
      do_reset();
      push_frame(0, 11, BE_2B);
      push_frame(0, 3, BE_1B);
      drive_srcs();
      run_done("t1", 100);
      chk("t1_grant01_cycles", g0_cycles, 14);
      chk("t1_frame_len", (eop_log.size() > 0) ? eop_log[0] - sop_log[0] : -1, 10);
      chk("t1_gap", (sop_log.size() > 1) ? sop_log[1] - eop_log[0] : -1, 4);

      // tie after reset
      do_reset();
      push_frame(0, 4, BE_3B);
      push_frame(1, 4, BE_4B);
      drive_srcs();
      run_done("t2", 100);
      chk("t2_order", (port_log.size() == 2) ? {port_log[0], port_log[1]} : 64'hFFFF, {32'd0, 32'd1});
      chk("t2_second_grant_after_gap", (sop_log.size() > 1) ? sop_log[1] - eop_log[0] : -1, 4);

      // round robin while s1 streams back-to-back
      do_reset();
      push_frame(1, 3, BE_4B);
      push_frame(1, 3, BE_1B);
      push_frame(1, 3, BE_2B);
      drive_srcs();
      step();
      push_frame(0, 3, BE_3B);
      drive_srcs();
      run_done("t3", 150);
      chk("t3_count", port_log.size(), 4);
      if (port_log.size() == 4) begin
         chk("t3_order", {port_log[0], port_log[1], port_log[2], port_log[3]},
             {32'd1, 32'd0, 32'd1, 32'd1});
      end

      // backpressure
      do_reset();
      ready_mode = 1;
      push_frame(1, 6, BE_2B);
      drive_srcs();
      run_done("t4", 100);
      chk("t4_stalls_seen", stall_cycles > 0, 1'b1);
      chk("t4_rd_low_when_not_ready", bp_viol, 0);
      chk("t4_hold_when_not_ready", hold_viol, 0);

      // watchdog on the MAX_WORDS=8 instance
      do_reset();
      f = fid;
      push_frame(1, 12, BE_3B);
      push_frame(1, 2, BE_1B);
      drive_srcs();
      run_done("t5", 100);
      chk("t5_wd_words", wd_words, 10);
      chk("t5_wd_word8", wd_word8, {1'b0, 1'b1, 4'h1, 12'(f), 16'd7, BE_4B});
      chk("t5_abort_count", wd_aborts, 1);
      chk("t5_abort_on_word8", wd_abort_word, 8);
      chk("t5_next_grant_after_gap", wd_sop_last - ((eop_log.size() > 0) ? eop_log[0] : 0), 4);
      chk("t5_main_no_abort", main_aborts, 0);

      // reset on word 5, then release with a sop already waiting
      do_reset();
      push_frame(1, 10, BE_4B);
      drive_srcs();
      i = 0;
      while (xfer_cnt < 4 && i < 50) begin step(); i++; end
      chk("t6_reached_word5", xfer_cnt, 4);
      chk("t6_pre_reset_busy", {m_vld, m_grant}, {1'b1, 2'b10});
      #2 reset_n = 1'b0;
      #1;
      chk("t6_rst_mac", {m_vld, m_sop, m_eop, m_data, m_be}, 0);
      chk("t6_rst_grant_abort", {m_grant, m_abort}, 0);
      chk("t6_rst_rd", {s1_rd, s0_rd}, 2'b00);
      model_on = 1'b0;
      clear_bench();
      push_frame(0, 3, BE_2B);
      drive_srcs();
      @(posedge clk_user);
      #1 reset_n = 1'b1;
      model_on = 1'b1;
      step();
      chk("t6_no_grant_edge1", m_grant, 2'b00);
      step();
      chk("t6_grant_edge2", m_grant, 2'b01);
      run_done("t6", 50);
      chk("t6_frame_seen", port_log.size(), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mac_tx_arbiter.md
MAC_TX_ARBITER -- requirements
Module: mac_tx_arbiter

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 2: number of idle cycles inserted after every frame eop.
REQ-002 The block SHALL have parameter MAX_WORDS, default 384: watchdog limit in words per frame.
REQ-003 The block SHALL have port clk_user_i, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-004 The block SHALL have port reset_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports s0_vld_i/s0_sop_i/s0_eop_i (in, 1), s0_data_i (in, 32) and s0_be_i (in, 2): the ARP requester stream.
REQ-006 The block SHALL have port s0_rd_o, output, 1 bit: the ARP word-accept strobe.
REQ-007 The block SHALL have ports s1_vld_i/s1_sop_i/s1_eop_i (in, 1), s1_data_i (in, 32), s1_be_i (in, 2) and s1_rd_o (out, 1): the IPv4/UDP requester stream, with the same meaning as the s0 ports.
REQ-008 The block SHALL have ports mac_tx_vld_o/mac_tx_sop_o/mac_tx_eop_o (out, 1), mac_tx_data_o (out, 32) and mac_tx_be_o (out, 2): the stream to the MAC transmitter.
REQ-009 The block SHALL have port mac_tx_ready_i, input, 1 bit: the MAC accepts a word this cycle.
REQ-010 The block SHALL have port grant_o, output, 2 bits: one-hot owner of the MAC; 00 means none.
REQ-011 The block SHALL have port abort_o, output, 1 bit: a one-cycle pulse when the watchdog truncates a frame.
REQ-012 The block SHALL use this be encoding on the final word: 00=4 bytes, 01=1 byte, 10=2 bytes, 11=3 bytes, MSB-first. On non-eop words be SHALL be ignored.

Function
REQ-013 A word SHALL transfer on any cycle where mac_tx_vld_o and mac_tx_ready_i are both high.
REQ-014 In BUSY, mac_tx_* SHALL be the combinational pass-through of the granted source, and sN_rd_o SHALL equal grant[N] AND mac_tx_ready_i AND sN_vld_i, with zero cycles of latency.
REQ-015 The non-granted source SHALL see rd_o=0, and the MAC outputs SHALL be 0 when not in BUSY.
REQ-016 The state machine SHALL have three states: IDLE, BUSY and GAP.
REQ-017 IDLE->BUSY SHALL occur on the cycle after a requester presents vld=1 with sop=1. The grant SHALL be registered on that transition.
REQ-018 Arbitration SHALL be round-robin: when both request in the same cycle, the port not granted last wins. After reset, last-grant SHALL be port 1, so s0 (ARP) wins the first tie.
REQ-019 A requester whose vld=1 with sop=0 in IDLE SHALL be dropped: its word is accepted (rd=1) and discarded, to resynchronise. This flush SHALL happen only while the other port is not being granted.
REQ-020 The grant SHALL hold until the transfer of a word with eop=1. BUSY SHALL then go to GAP, grant_o SHALL become 00, and the gap counter SHALL load GAP_CYCLES-1.
REQ-021 GAP SHALL count down to 0 and then return to IDLE. With GAP_CYCLES=0, BUSY SHALL go directly to IDLE.
REQ-022 A word counter (9+ bits, wide enough for MAX_WORDS) SHALL clear on the grant and increment on every transfer in BUSY.
REQ-023 When a transfer occurs with the counter equal to MAX_WORDS-1 and the source eop=0, the block SHALL:
  - force mac_tx_eop_o=1 and mac_tx_be_o=00 on that word;
  - pulse abort_o for 1 cycle;
  - enter the DRAIN sub-mode of GAP.
REQ-024 In DRAIN, the block SHALL accept and discard source words (rd=1, MAC vld=0) up to and including the source eop, then run the normal gap.
REQ-025 A source that drops vld mid-frame in BUSY SHALL keep the grant. MAC vld SHALL be low on those cycles, and the watchdog SHALL NOT advance.
REQ-026 A new sop arriving on the granted port before eop SHALL be forwarded unchanged; the block does no framing check beyond eop.
REQ-027 If mac_tx_ready_i is low, all outputs SHALL hold their values, because the source must hold its outputs while rd is low.

Reset
REQ-028 On reset_n_i=0, the block SHALL asynchronously enter IDLE with grant_o=00, last-grant=port 1, counters=0, abort_o=0, all mac_tx_* =0 and all rd_o=0.
REQ-029 Reset mid-frame SHALL truncate without an eop. The MAC SHALL be reset with the same reset so that it discards the partial frame.
REQ-030 After reset release, the first grant SHALL be possible on the second clock edge.

Structure
REQ-031 The shared package SHALL hold:
  - the be encoding constants (BE_4B, BE_1B, BE_2B, BE_3B);
  - the state enum (IDLE, BUSY, GAP) and the DRAIN flag;
  - the port index constants (PORT_ARP=0, PORT_IP=1).
REQ-032 The round-robin 2-way grant decision SHALL be a sub-module rr_arb2 (request[1:0], last[1:0] -> grant[1:0]), kept purely combinational. All other logic SHALL be in a single module.

Verification
REQ-033 Single ARP frame: s0 sends 11 words (sop on w0, eop on w10, be=10) with ready=1 -> the MAC sees 11 identical words, grant_o=01 for 11 cycles, then 2 idle cycles.
REQ-034 Tie after reset: s0 and s1 both raise sop in the same cycle -> s0 is granted first; s1 is granted in the first IDLE cycle after the 2-cycle gap, and its data is never interleaved.
REQ-035 Round-robin: s1 streams frames back-to-back and s0 holds a request -> the grants alternate s1, s0, s1; s0 waits at most one frame.
REQ-036 Backpressure: ready toggles 1,0,0,1 during a frame -> no word is duplicated or lost, and s1_rd_o=0 on the ready=0 cycles.
REQ-037 Watchdog: with MAX_WORDS=8, s1 sends 12 words -> the MAC gets 8 words with eop and be=00 on word 8, abort_o pulses once, words 9-12 are drained, and the next grant follows the gap.
REQ-038 Reset on word 5 of a frame -> all outputs are 0 immediately, and the next sop is granted from IDLE.
